// File: rtl/rom_loader.sv
// Bulk loader: assembles a big-endian byte stream into 16-bit instruction words and writes them
// from address 0 while holding the CPU in reset. Optional trailing checksum: ROM_LOADER_CHECKSUM_EN.
module rom_loader #(
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MAX_WORDS = 32768
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded
);

    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
`ifdef ROM_LOADER_CHECKSUM_EN
        S_CSUM_HI,
        S_CSUM_LO,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_len_hi;
    logic [15:0]       r_len;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [15:0]       r_words;
    logic              w_accept;
    logic              w_start_ok;
    logic [15:0]       w_len;
    logic [15:0]       w_words_inc;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0]        r_csum_hi;
    logic [15:0]       r_sum;
`endif

    assign w_len       = {r_len_hi, in_data};
    assign w_words_inc = r_words + 16'd1;
    assign w_accept    = in_valid && in_ready;
    assign w_start_ok  = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);

    // All status outputs are pure decodes of the state so DONE/ERR stickiness and the
    // clear-on-start behaviour fall out of the state transitions.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b1;
        case (r_state)
            S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO: in_ready = 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
            S_CSUM_HI, S_CSUM_LO:                     in_ready = 1'b1;
`endif
            S_IDLE, S_DONE, S_ERR:                    busy     = 1'b0;
            default:                                  in_ready = 1'b0;
        endcase
    end

    assign mem_we       = (r_state == S_WRITE);
    assign done         = (r_state == S_DONE);
    assign error        = (r_state == S_ERR);
    assign cpu_hold     = busy || error;
    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;
    assign words_loaded = r_words;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) w_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (w_accept) w_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_accept) begin
                    if (w_len == 16'd0)                  w_next = S_DONE;
                    else if ({1'b0, w_len} > MAX_LEN)    w_next = S_ERR;
                    else                                 w_next = S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                if (w_accept) w_next = S_DATA_LO;
            end
            S_DATA_LO: begin
                if (w_accept) w_next = S_WRITE;
            end
            S_WRITE: begin
                if (w_words_inc == r_len) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                    w_next = S_CSUM_HI;
`else
                    w_next = S_DONE;
`endif
                end else begin
                    w_next = S_DATA_HI;
                end
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            S_CSUM_HI: begin
                if (w_accept) w_next = S_CSUM_LO;
            end
            S_CSUM_LO: begin
                if (w_accept) w_next = ({r_csum_hi, in_data} == r_sum) ? S_DONE : S_ERR;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_len_hi <= '0;
            r_len    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_words  <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
            r_csum_hi <= '0;
            r_sum     <= '0;
`endif
        end else begin
            if (w_start_ok) begin
                r_words <= '0;
                r_addr  <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
                r_sum   <= '0;
`endif
            end
            case (r_state)
                S_LEN_HI:  if (w_accept) r_len_hi      <= in_data;
                S_LEN_LO:  if (w_accept) r_len         <= w_len;
                S_DATA_HI: if (w_accept) r_wdata[15:8] <= in_data;
                S_DATA_LO: if (w_accept) r_wdata[7:0]  <= in_data;
                S_WRITE: begin
                    // Address wraps naturally at 2^ADDR_W, only hit when N == MAX_WORDS == 2^ADDR_W.
                    r_words <= w_words_inc;
                    r_addr  <= r_addr + 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
                    r_sum   <= r_sum + r_wdata;
`endif
                end
`ifdef ROM_LOADER_CHECKSUM_EN
                S_CSUM_HI: if (w_accept) r_csum_hi <= in_data;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// Randomized self-checking bench for rom_loader; expected writes and outcome come from a
// queue-based model of the load protocol (honours ROM_LOADER_CHECKSUM_EN).
module tb_rom_loader;

    localparam int AW   = 15;
    localparam int MAXW = 32768;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_ready, mem_we, cpu_hold, busy, done, error;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata, words_loaded;

    int n_tests = 0;
    int n_fail  = 0;

    logic [AW-1:0] wa[$];
    logic [15:0]   wd[$];
    logic [AW-1:0] ea[$];
    logic [15:0]   ed[$];
    logic [15:0]   tx_words[$];
    int            rdy_bad = 0;
    logic          exp_done, exp_err;
    logic [15:0]   exp_wl;

    rom_loader #(.ADDR_W(AW), .DATA_W(16), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
            if (in_ready) rdy_bad++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int cnt = 0;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        if (!in_ready) begin
            n_tests++; n_fail++;
            $display("FAIL byte_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, cnt);
        end
        @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Model: a valid header yields N writes of tx_words at addresses 0..N-1; outcome from N and checksum.
    task automatic run_load(input logic [15:0] n, input logic [15:0] csum_delta, input int maxgap);
        int unsigned sum = 0;
        logic [15:0] cs;
        logic valid;
        valid = (n != 0) && (int'(n) <= MAXW);
        ea.delete(); ed.delete(); wa.delete(); wd.delete();
        rdy_bad = 0;
        if (valid)
            for (int i = 0; i < int'(n); i++) begin
                ea.push_back(AW'(i));
                ed.push_back(tx_words[i]);
                sum = sum + tx_words[i];
            end
        cs       = 16'(sum) + csum_delta;
        exp_wl   = valid ? n : 16'd0;
        exp_err  = (int'(n) > MAXW);
        exp_done = !exp_err;
`ifdef ROM_LOADER_CHECKSUM_EN
        if (valid && csum_delta != 0) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
        end
`endif
        pulse_start();
        send_byte(n[15:8], $urandom_range(maxgap));
        send_byte(n[7:0], $urandom_range(maxgap));
        if (valid) begin
            for (int i = 0; i < int'(n); i++) begin
                send_byte(tx_words[i][15:8], $urandom_range(maxgap));
                send_byte(tx_words[i][7:0], $urandom_range(maxgap));
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            send_byte(cs[15:8], $urandom_range(maxgap));
            send_byte(cs[7:0], $urandom_range(maxgap));
`endif
        end
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests++;
        if ({in_ready, mem_we, busy, done, error, cpu_hold} !== 6'b0 || mem_addr !== '0 ||
            mem_wdata !== '0 || words_loaded !== '0) begin
            n_fail++;
            $display("FAIL reset_state: rdy/we/busy/done/err/hold=%b addr=%h data=%h wl=%0d, required all 0",
                     {in_ready, mem_we, busy, done, error, cpu_hold}, mem_addr, mem_wdata, words_loaded);
        end
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({busy, done, error, cpu_hold} !== 4'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy/done/err/hold=%b, required 0000", {busy, done, error, cpu_hold});
        end
    endtask

    task automatic test_load(input string name, input logic [15:0] n, input logic [15:0] delta, input int maxgap);
        run_load(n, delta, maxgap);
        n_tests++;
        if (wa.size() != ea.size()) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d, required %0d", name, wa.size(), ea.size());
        end else begin
            for (int i = 0; i < ea.size(); i++) begin
                n_tests++;
                if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
                    n_fail++;
                    $display("FAIL %s write%0d: got (%h,%h), required (%h,%h)", name, i, wa[i], wd[i], ea[i], ed[i]);
                end
            end
        end
        n_tests++;
        if (done !== exp_done || error !== exp_err || cpu_hold !== exp_err || busy !== 1'b0 ||
            words_loaded !== exp_wl || rdy_bad != 0) begin
            n_fail++;
            $display("FAIL %s status: done=%b err=%b hold=%b busy=%b wl=%0d rdy_in_write=%0d, required done=%b err=%b hold=%b busy=0 wl=%0d rdy_in_write=0",
                     name, done, error, cpu_hold, busy, words_loaded, rdy_bad, exp_done, exp_err, exp_err, exp_wl);
        end
    endtask

    task automatic test_basic();
        tx_words = '{16'h1234, 16'hABCD, 16'h0001};
        test_load("basic", 16'd3, 16'd0, 0);
    endtask

    task automatic test_zero_len();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0 || cpu_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len_timing: done=%b busy=%b hold=%b, required 1 0 0", done, busy, cpu_hold);
        end
        in_valid = 1'b0;
        tx_words.delete();
        test_load("zero_len", 16'd0, 16'd0, 1);
    endtask

    task automatic test_overflow();
        tx_words.delete();
        test_load("overflow", 16'h8001, 16'd0, 2);
        pulse_start();
        n_tests++;
        if (error !== 1'b0 || done !== 1'b0 || busy !== 1'b1 || cpu_hold !== 1'b1 || in_ready !== 1'b1 ||
            words_loaded !== 16'd0) begin
            n_fail++;
            $display("FAIL restart_after_err: err=%b done=%b busy=%b hold=%b rdy=%b wl=%0d, required 0 0 1 1 1 0",
                     error, done, busy, cpu_hold, in_ready, words_loaded);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_gaps();
        tx_words = '{16'h5A3C, 16'hC3E1};
        test_load("gaps", 16'd2, 16'd0, 5);
    endtask

    task automatic test_reset_mid();
        wa.delete(); wd.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_byte(8'hDE, 1);
        send_byte(8'hAD, 0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        pulse_start();
        n_tests++;
        if (busy !== 1'b1 || cpu_hold !== 1'b1 || words_loaded !== 16'd1 || mem_addr !== AW'(1) || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL start_while_busy: busy=%b hold=%b wl=%0d addr=%0d rdy=%b, required 1 1 1 1 1",
                     busy, cpu_hold, words_loaded, mem_addr, in_ready);
        end
        send_byte(8'hBE, 0);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || cpu_hold !== 1'b0 || mem_we !== 1'b0 || words_loaded !== 16'd0 ||
            in_ready !== 1'b0 || wa.size() != 1) begin
            n_fail++;
            $display("FAIL reset_mid_load: busy=%b hold=%b we=%b wl=%0d rdy=%b writes=%0d, required 0 0 0 0 0 1",
                     busy, cpu_hold, mem_we, words_loaded, in_ready, wa.size());
        end
    endtask

`ifdef ROM_LOADER_CHECKSUM_EN
    task automatic test_csum_bad();
        tx_words = '{16'h0005};
        test_load("csum_bad", 16'd1, 16'd1, 0);
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            int n;
            logic [15:0] delta;
            n = $urandom_range(12, 1);
            tx_words.delete();
            for (int i = 0; i < n; i++) tx_words.push_back(16'($urandom));
            delta = 16'd0;
`ifdef ROM_LOADER_CHECKSUM_EN
            if ($urandom_range(1) == 1) delta = 16'($urandom_range(65535, 1));
`endif
            test_load("random", 16'(n), delta, $urandom_range(3));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_overflow();
        test_gaps();
        test_reset_mid();
`ifdef ROM_LOADER_CHECKSUM_EN
        test_csum_bad();
`endif
        test_random();
        test_basic();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Sequences a bulk load of the 16-bit instruction memory (15-bit word address) from an 8-bit byte stream.
- Assembles bytes into instruction words, writes them at incrementing addresses starting from 0, and holds the CPU in reset while loading.
- Releases the CPU on completion so it fetches the new program from address 0.
- Sits between the host/UART byte source and the instruction-memory write port.

Parameters:
- ADDR_W, 15, instruction-memory word-address width.
- DATA_W, 16, instruction width. Fixed at 2 bytes per word, high byte first.
- MAX_WORDS, 32768, largest legal load length. Must be ≤ 2^ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a load. Honoured only in IDLE, DONE or ERR.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  byte accepted when in_valid && in_ready on a clk edge.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  DATA_W  write data.
- cpu_hold  out  1  holds CPU in reset while high.
- busy  out  1  load in progress.
- done  out  1  sticky; last load completed successfully.
- error  out  1  sticky; last load aborted.
- words_loaded  out  16  count of words written in the current/last load.

Behaviour:
- Reset (sync, active-high; takes priority over all inputs):
  - state=IDLE.
  - in_ready, mem_we, busy, done, error = 0.
  - mem_addr, mem_wdata, words_loaded = 0.
  - cpu_hold = 0.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CSUM_HI, CSUM_LO (CSUM states only with feature), DONE, ERR.
- Starting a load: start in IDLE/DONE/ERR → LEN_HI. On that edge: clear done, error and words_loaded; set mem_addr=0, busy=1, cpu_hold=1. start in any other state is ignored.
- in_ready=1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM_HI, CSUM_LO. The FSM advances only on an accepted byte; gaps in in_valid stall indefinitely, with no timeout.
- Length header: LEN_HI then LEN_LO form a 16-bit big-endian word count N.
  - N=0 → DONE. No writes.
  - N>MAX_WORDS → ERR.
  - Otherwise → DATA_HI.
- Word assembly: DATA_HI latches byte as wdata[15:8]. DATA_LO latches byte as wdata[7:0] and → WRITE.
- WRITE (exactly 1 cycle):
  - mem_we=1, with mem_addr and mem_wdata stable. in_ready=0.
  - Next edge: words_loaded+1. mem_addr+1, wrapping to 0 at 2^ADDR_W; only reachable when N=MAX_WORDS=2^ADDR_W.
  - If words_loaded+1==N, go to CSUM_HI (feature on) or DONE; otherwise DATA_HI.
- Timing: write latency is 1 cycle after low-byte acceptance. Peak throughput is 1 word per 3 cycles.
- DONE: busy=0, done=1, cpu_hold=0. The CPU runs from address 0.
- ERR: busy=0, error=1, cpu_hold stays 1 until a new start or reset.
- mem_we is never high outside WRITE.
- Reset mid-load: returns to IDLE with cpu_hold=0. Already-written memory words are not erased.
- start coinciding with reset: reset wins.
- A byte offered while in_ready=0 is not consumed; the source must hold it.

Optional Feature:
- Macro: ROM_LOADER_CHECKSUM_EN.
- Enabled:
  - A running 16-bit sum (mod 2^16) of all written words is kept; cleared on start.
  - After the last word, CSUM_HI/CSUM_LO accept a big-endian 16-bit checksum.
  - Match → DONE; mismatch → ERR.
  - For N=0 no checksum is read (→ DONE directly).
- Disabled:
  - CSUM states and the summing logic are absent.
  - The last WRITE goes straight to DONE.

Test Plan:
1. Reset, pulse start, stream 00 03 | 12 34 | AB CD | 00 01 with in_valid always 1 → mem_we pulses 3 times. Writes: (0,0x1234), (1,0xABCD), (2,0x0001). Then done=1, cpu_hold=0, words_loaded=3. With checksum enabled, append BE 02 → done=1.
2. start, header 00 00 → DONE two byte acceptances after start; no mem_we; done=1.
3. start, header 80 01 (N=32769) → ERR; error=1; cpu_hold=1; no mem_we. A following start clears error and re-enters LEN_HI.
4. Load 2 words with in_valid toggling every other cycle and 5-cycle gaps → same writes as with a continuous stream; in_ready=0 on each WRITE cycle.
5. Assert reset after the first word is written, mid-second word → next cycle state IDLE, busy=0, cpu_hold=0, mem_we=0, words_loaded=0. A start pulse during busy (without reset) is ignored.
6. (ROM_LOADER_CHECKSUM_EN) Load 00 01 | 00 05 | 00 06 (wrong checksum) → error=1, done=0, cpu_hold=1.
